// File: rtl/sumador_serie_if.sv
// sumador_serie_if: start/busy/done handshake and operand/result bus
// of the bit-serial adder. SUMADOR_SERIE_OVF_EN adds the ovf line.
interface sumador_serie_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] suma;
  logic             C_out;
`ifdef SUMADOR_SERIE_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start, A, B,
`ifdef SUMADOR_SERIE_OVF_EN
    input  ovf,
`endif
    input  busy, done, suma, C_out
  );

  modport slave (
    input  start, A, B,
`ifdef SUMADOR_SERIE_OVF_EN
    output ovf,
`endif
    output busy, done, suma, C_out
  );
endinterface

// File: rtl/sumador_serie.sv
// sumador_serie: LSB-first bit-serial adder, one full-adder cell.
// SUMADOR_SERIE_OVF_EN adds a registered signed-overflow flag.
module sumador_serie #(
  parameter int WIDTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  sumador_serie_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    REPOSO = 2'd0,
    SUMA   = 2'd1,
    FIN    = 2'd2
  } state_t;

  state_t           state;
  state_t           next;
  logic [WIDTH-1:0] reg_a;
  logic [WIDTH-1:0] reg_b;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             last;
  logic             load;
  logic             step;
  logic             fin;
  logic             s;
  logic             c_next;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] suma_q;
  logic             c_out_q;
`ifdef SUMADOR_SERIE_OVF_EN
  logic             c_msb;
  logic             ovf_q;
`endif

  assign last   = (cnt == CW'(WIDTH - 1));
  assign s      = reg_a[0] ^ reg_b[0] ^ carry;
  assign c_next = (reg_a[0] & reg_b[0])
                | (reg_a[0] & carry)
                | (reg_b[0] & carry);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= REPOSO;
    else        state <= next;
  end

  // next-state logic
  always_comb begin
    next = state;
    unique case (state)
      REPOSO:  if (bus.start) next = SUMA;
      SUMA:    if (last) next = FIN;
      FIN:     next = REPOSO;
      default: next = REPOSO;
    endcase
  end

  // per-state datapath strobes
  always_comb begin
    load = 1'b0;
    step = 1'b0;
    fin  = 1'b0;
    unique case (state)
      REPOSO:  load = bus.start;
      SUMA:    step = 1'b1;
      FIN:     fin  = 1'b1;
      default: ;
    endcase
  end

  // operand shifters, carry flop, bit counter and accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_a <= '0;
      reg_b <= '0;
      acc   <= '0;
      cnt   <= '0;
      carry <= 1'b0;
    end else if (load) begin
      reg_a <= bus.A;
      reg_b <= bus.B;
      acc   <= '0;
      cnt   <= '0;
      carry <= 1'b0;
    end else if (step) begin
      reg_a <= reg_a >> 1;
      reg_b <= reg_b >> 1;
      acc   <= {s, acc[WIDTH-1:1]};
      cnt   <= cnt + 1'b1;
      carry <= c_next;
    end
  end

`ifdef SUMADOR_SERIE_OVF_EN
  // carry entering the MSB, kept for the overflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            c_msb <= 1'b0;
    else if (step && last) c_msb <= carry;
  end
`endif

  // registered handshake and result, updated once per operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      suma_q  <= '0;
      c_out_q <= 1'b0;
`ifdef SUMADOR_SERIE_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      busy_q <= (next != REPOSO);
      done_q <= fin;
      if (fin) begin
        suma_q  <= acc;
        c_out_q <= carry;
`ifdef SUMADOR_SERIE_OVF_EN
        ovf_q   <= c_msb ^ carry;
`endif
      end
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.suma  = suma_q;
  assign bus.C_out = c_out_q;
`ifdef SUMADOR_SERIE_OVF_EN
  assign bus.ovf   = ovf_q;
`endif
endmodule
